decode_stage: RTL and testbench
===============================

# decode_stage

Parametrised decode stage for the pipelined MIPS core: owns the F/D pipeline register (stall/flush), an XLEN-wide, NREG-entry register file with write-through bypass, sign extension, and early branch resolution in D. Forwarding from M and W feeds the branch comparator, which supports six conditions. It sits between the fetch path and the D/E pipeline register and is driven by the hazard unit.

## Interface
Parameters:
- XLEN, 32, datapath width; legal range 18..64.
- NREG, 32, register count; a power of two, 2..32. RA_W = $clog2(NREG).

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- stall_D  in  1  hold the F/D register.
- flush_D  in  1  load a bubble into the F/D register.
- inst_F  in  32  fetched instruction.
- pc_plus4_F  in  XLEN  PC+4 of inst_F.
- reg_write_W  in  1  writeback enable.
- reg_id_W  in  RA_W  writeback register index.
- result_W  in  XLEN  writeback data.
- alu_out_M  in  XLEN  M-stage forwarding source.
- fwd_a_D, fwd_b_D  in  2 each  comparator source select: 00 regfile, 01 alu_out_M, 10 result_W, 11 regfile.
- branch_D  in  1  the instruction in D is a conditional branch.
- br_mode_D  in  3  branch condition (see Operation).
- inst_D  out  32  registered instruction.
- pc_plus4_D  out  XLEN  registered PC+4.
- valid_D  out  1  F/D holds a real instruction.
- rs_out_D, rt_out_D  out  XLEN  register reads for inst_D[25:21] and inst_D[20:16]. Only the low RA_W bits of each field index the file.
- imm_D  out  XLEN  sign-extended inst_D[15:0].
- pc_br_D  out  XLEN  branch target.
- pc_src_D  out  1  branch taken.

## Operation
F/D register, priority reset > flush_D > stall_D > load:
- reset or flush_D: inst_D=0 (nop), pc_plus4_D=0, valid_D=0.
- stall_D only: all three fields hold.
- Otherwise: load inst_F and pc_plus4_F, and set valid_D=1.

Register file:
- Index 0 reads 0 and ignores writes.
- Write occurs when reg_write_W=1 and reg_id_W!=0.
- reset clears all entries to 0. It also suppresses any write in the same cycle.
- Bypass: a read whose index equals reg_id_W, with a write enabled in that cycle, returns result_W combinationally. Otherwise it returns the stored value.

Datapath:
- imm_D = {{(XLEN-16){inst_D[15]}}, inst_D[15:0]}.
- pc_br_D = pc_plus4_D + (imm_D << 2), truncated to XLEN bits (wraps modulo 2^XLEN).
- Comparator operands: a = mux(fwd_a_D) and b = mux(fwd_b_D). Forwarding only feeds the comparator; rs_out_D and rt_out_D are always the regfile/bypass values.

br_mode_D, with signed compares on XLEN bits:
- 0 EQ: a==b
- 1 NE: a!=b
- 2 LEZ: a<=0
- 3 GTZ: a>0
- 4 LTZ: a<0
- 5 GEZ: a>=0
- 6, 7: never taken

pc_src_D = branch_D & valid_D & cond. A bubble therefore never redirects the PC.

## Timing
- inst_F and pc_plus4_F appear on inst_D and pc_plus4_D one cycle after the capturing edge.
- All other outputs are combinational from the F/D register, the register file and the D-stage inputs.
- Register-file write latency: the stored value is visible from the cycle after the edge. The bypass makes it visible in the write cycle itself.
- stall_D and flush_D asserted together: the flush wins.
- After reset deassertion: valid_D=0 and pc_src_D=0 until the first load edge.
- Reset asserted mid-operation clears the F/D register and the file at the next edge. The same-cycle W write is lost.

## Test plan
- Reset, then load inst_F=0x1000FFFF (beq $0,$0,-1) with pc_plus4_F=0x100 -> next cycle imm_D=0xFFFFFFFF, pc_br_D=0x0FC, pc_src_D=1 (branch_D=1, mode 0).
- Write reg 5=0xDEAD in cycle n, with inst_D reading rs=5 in the same cycle -> rs_out_D=0xDEAD in cycle n (bypass) and in cycle n+1 (stored). A write to reg 0 reads back 0.
- Set fwd_a_D=01 with alu_out_M=0xFFFFFFFF, mode 4 (LTZ) -> pc_src_D=1. Same setup with mode 3 (GTZ) -> 0. Mode 6 -> 0.
- Hold stall_D for 3 cycles while inst_F changes -> inst_D holds. Assert flush_D together with stall_D -> inst_D=0, valid_D=0, pc_src_D=0 even with branch_D=1.
- Wrap: pc_plus4_D=0xFFFFFFFC, imm=1 -> pc_br_D=0x00000000. Repeat with XLEN=16 is illegal; rerun the suite at XLEN=64, NREG=16, where regs 16..31 alias to 0..15.
- Assert reset mid-stream with a W write pending -> at the next edge all registers read 0 and valid_D=0.

Source files
------------

// File: rtl/decode_stage_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | decode_stage_if : D-stage bus between fetch/hazard side and decode |
// | Revision 1.0                                                       |
// +------------------------------------------------------------------+
interface decode_stage_if #(
  parameter int XLEN = 32,
  parameter int NREG = 32
);
  localparam int RA_W = $clog2(NREG);

  logic            stall_D;
  logic            flush_D;
  logic [31:0]     inst_F;
  logic [XLEN-1:0] pc_plus4_F;
  logic            reg_write_W;
  logic [RA_W-1:0] reg_id_W;
  logic [XLEN-1:0] result_W;
  logic [XLEN-1:0] alu_out_M;
  logic [1:0]      fwd_a_D;
  logic [1:0]      fwd_b_D;
  logic            branch_D;
  logic [2:0]      br_mode_D;

  logic [31:0]     inst_D;
  logic [XLEN-1:0] pc_plus4_D;
  logic            valid_D;
  logic [XLEN-1:0] rs_out_D;
  logic [XLEN-1:0] rt_out_D;
  logic [XLEN-1:0] imm_D;
  logic [XLEN-1:0] pc_br_D;
  logic            pc_src_D;

  modport master (
    output stall_D, flush_D, inst_F, pc_plus4_F, reg_write_W, reg_id_W,
           result_W, alu_out_M, fwd_a_D, fwd_b_D, branch_D, br_mode_D,
    input  inst_D, pc_plus4_D, valid_D, rs_out_D, rt_out_D, imm_D,
           pc_br_D, pc_src_D
  );

  modport slave (
    input  stall_D, flush_D, inst_F, pc_plus4_F, reg_write_W, reg_id_W,
           result_W, alu_out_M, fwd_a_D, fwd_b_D, branch_D, br_mode_D,
    output inst_D, pc_plus4_D, valid_D, rs_out_D, rt_out_D, imm_D,
           pc_br_D, pc_src_D
  );
endinterface
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// +------------------------------------------------------------------+
// | decode_stage : F/D register, bypassed regfile, early branch in D  |
// | Revision 1.0                                                       |
// +------------------------------------------------------------------+
module decode_stage #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic          clk,
  input  logic          reset,
  decode_stage_if.slave bus
);
  localparam int RA_W = $clog2(NREG);

  localparam logic [2:0] BR_EQ  = 3'd0;
  localparam logic [2:0] BR_NE  = 3'd1;
  localparam logic [2:0] BR_LEZ = 3'd2;
  localparam logic [2:0] BR_GTZ = 3'd3;
  localparam logic [2:0] BR_LTZ = 3'd4;
  localparam logic [2:0] BR_GEZ = 3'd5;

  logic [31:0]     inst_q;
  logic [XLEN-1:0] pc_plus4_q;
  logic            valid_q;
  logic [XLEN-1:0] regs [NREG];

  logic            wr_en;
  logic [RA_W-1:0] rs_idx;
  logic [RA_W-1:0] rt_idx;
  logic [XLEN-1:0] rs_val;
  logic [XLEN-1:0] rt_val;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] cmp_a;
  logic [XLEN-1:0] cmp_b;
  logic            cond;

  always_ff @(posedge clk) begin
    if (reset || bus.flush_D) begin
      inst_q     <= '0;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
    end else if (!bus.stall_D) begin
      inst_q     <= bus.inst_F;
      pc_plus4_q <= bus.pc_plus4_F;
      valid_q    <= 1'b1;
    end
  end

  // A write coinciding with reset is dropped, so it also must not bypass.
  assign wr_en = bus.reg_write_W && (bus.reg_id_W != '0) && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[bus.reg_id_W] <= bus.result_W;
    end
  end

  assign rs_idx = inst_q[21 +: RA_W];
  assign rt_idx = inst_q[16 +: RA_W];

  always_comb begin
    rs_val = regs[rs_idx];
    rt_val = regs[rt_idx];
    if (wr_en && (rs_idx == bus.reg_id_W)) rs_val = bus.result_W;
    if (wr_en && (rt_idx == bus.reg_id_W)) rt_val = bus.result_W;
  end

  assign imm = {{(XLEN-16){inst_q[15]}}, inst_q[15:0]};

  always_comb begin
    cmp_a = rs_val;
    cmp_b = rt_val;
    case (bus.fwd_a_D)
      2'b01:   cmp_a = bus.alu_out_M;
      2'b10:   cmp_a = bus.result_W;
      default: cmp_a = rs_val;
    endcase
    case (bus.fwd_b_D)
      2'b01:   cmp_b = bus.alu_out_M;
      2'b10:   cmp_b = bus.result_W;
      default: cmp_b = rt_val;
    endcase
  end

  // Zero tests read the sign bit directly: signed compare against zero.
  always_comb begin
    cond = 1'b0;
    case (bus.br_mode_D)
      BR_EQ:   cond = (cmp_a == cmp_b);
      BR_NE:   cond = (cmp_a != cmp_b);
      BR_LEZ:  cond = cmp_a[XLEN-1] || (cmp_a == '0);
      BR_GTZ:  cond = !cmp_a[XLEN-1] && (cmp_a != '0);
      BR_LTZ:  cond = cmp_a[XLEN-1];
      BR_GEZ:  cond = !cmp_a[XLEN-1];
      default: cond = 1'b0;
    endcase
  end

  assign bus.inst_D     = inst_q;
  assign bus.pc_plus4_D = pc_plus4_q;
  assign bus.valid_D    = valid_q;
  assign bus.rs_out_D   = rs_val;
  assign bus.rt_out_D   = rt_val;
  assign bus.imm_D      = imm;
  assign bus.pc_br_D    = pc_plus4_q + (imm << 2);
  assign bus.pc_src_D   = bus.branch_D && valid_q && cond;
endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_decode_stage : scoreboard bench, XLEN=32/NREG=32 and 64/16      |
// | Revision 1.0                                                       |
// +------------------------------------------------------------------+
module tb_decode_stage;
  logic clk;
  logic reset;

  decode_stage_if #(.XLEN(32), .NREG(32)) a_if ();
  decode_stage_if #(.XLEN(64), .NREG(16)) b_if ();

  decode_stage #(.XLEN(32), .NREG(32)) dut_a (
    .clk(clk), .reset(reset), .bus(a_if.slave)
  );
  decode_stage #(.XLEN(64), .NREG(16)) dut_b (
    .clk(clk), .reset(reset), .bus(b_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic push(input string tag, input logic [63:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic pop_check(input logic [63:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed=%h required=<queued value>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s: observed=%h required=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1'b1;
    a_if.stall_D = 0; a_if.flush_D = 0; a_if.inst_F = '0; a_if.pc_plus4_F = '0;
    a_if.reg_write_W = 0; a_if.reg_id_W = '0; a_if.result_W = '0; a_if.alu_out_M = '0;
    a_if.fwd_a_D = 2'b00; a_if.fwd_b_D = 2'b00; a_if.branch_D = 0; a_if.br_mode_D = 3'd0;
    b_if.stall_D = 0; b_if.flush_D = 0; b_if.inst_F = 32'h02A5_8000;
    b_if.pc_plus4_F = 64'h0000_0001_0000_0000;
    b_if.reg_write_W = 0; b_if.reg_id_W = '0; b_if.result_W = '0; b_if.alu_out_M = '0;
    b_if.fwd_a_D = 2'b00; b_if.fwd_b_D = 2'b00; b_if.branch_D = 0; b_if.br_mode_D = 3'd0;
    tick();
    tick();

    // reset state, with a branch request that must be masked by valid_D=0
    reset = 1'b0;
    a_if.inst_F = 32'h1000_FFFF; a_if.pc_plus4_F = 32'h0000_0100;
    a_if.branch_D = 1; a_if.br_mode_D = 3'd0;
    push("rst_valid", 64'd0); push("rst_inst", 64'd0); push("rst_pcsrc", 64'd0);
    #1;
    pop_check(64'(a_if.valid_D)); pop_check(64'(a_if.inst_D)); pop_check(64'(a_if.pc_src_D));

    // beq $0,$0,-1 at PC+4=0x100
    push("beq_inst", 64'h1000_FFFF); push("beq_imm", 64'hFFFF_FFFF);
    push("beq_pcbr", 64'h0000_00FC); push("beq_pcsrc", 64'd1); push("beq_valid", 64'd1);
    tick();
    pop_check(64'(a_if.inst_D)); pop_check(64'(a_if.imm_D));
    pop_check(64'(a_if.pc_br_D)); pop_check(64'(a_if.pc_src_D)); pop_check(64'(a_if.valid_D));

    // write-through bypass then stored value for reg 5
    a_if.branch_D = 0; a_if.inst_F = 32'h00A0_0000;
    tick();
    a_if.reg_write_W = 1; a_if.reg_id_W = 5'd5; a_if.result_W = 32'h0000_DEAD;
    push("bypass_rs", 64'h0000_DEAD);
    #1;
    pop_check(64'(a_if.rs_out_D));
    tick();
    a_if.reg_write_W = 0; a_if.result_W = 32'h0000_1234;
    push("stored_rs", 64'h0000_DEAD); push("rt_zero", 64'd0);
    #1;
    pop_check(64'(a_if.rs_out_D)); pop_check(64'(a_if.rt_out_D));

    // writes to reg 0 neither bypass nor stick
    a_if.reg_write_W = 1; a_if.reg_id_W = 5'd0; a_if.result_W = 32'h0000_BEEF;
    push("r0_bypass", 64'd0);
    #1;
    pop_check(64'(a_if.rt_out_D));
    tick();
    a_if.reg_write_W = 0;
    push("r0_stored", 64'd0);
    #1;
    pop_check(64'(a_if.rt_out_D));

    // comparator forwarding and conditions
    a_if.branch_D = 1; a_if.fwd_a_D = 2'b01; a_if.alu_out_M = 32'hFFFF_FFFF;
    a_if.br_mode_D = 3'd4; push("fwdM_ltz", 64'd1); #1; pop_check(64'(a_if.pc_src_D));
    a_if.br_mode_D = 3'd3; push("fwdM_gtz", 64'd0); #1; pop_check(64'(a_if.pc_src_D));
    a_if.br_mode_D = 3'd6; push("mode6", 64'd0); #1; pop_check(64'(a_if.pc_src_D));
    a_if.br_mode_D = 3'd2; push("fwdM_lez", 64'd1); #1; pop_check(64'(a_if.pc_src_D));
    a_if.fwd_a_D = 2'b10; a_if.result_W = 32'h0000_0005;
    a_if.br_mode_D = 3'd3; push("fwdW_gtz", 64'd1); #1; pop_check(64'(a_if.pc_src_D));
    a_if.br_mode_D = 3'd5; push("fwdW_gez", 64'd1); #1; pop_check(64'(a_if.pc_src_D));
    push("rs_not_fwd", 64'h0000_DEAD); #1; pop_check(64'(a_if.rs_out_D));
    a_if.fwd_a_D = 2'b00; a_if.fwd_b_D = 2'b01; a_if.alu_out_M = 32'h0000_DEAD;
    a_if.br_mode_D = 3'd0; push("fwdb_eq", 64'd1); #1; pop_check(64'(a_if.pc_src_D));
    a_if.br_mode_D = 3'd1; push("fwdb_ne", 64'd0); #1; pop_check(64'(a_if.pc_src_D));
    a_if.fwd_a_D = 2'b11; a_if.fwd_b_D = 2'b11;
    a_if.br_mode_D = 3'd1; push("fwd11_ne", 64'd1); #1; pop_check(64'(a_if.pc_src_D));

    // stall holds for three cycles while inst_F moves
    a_if.fwd_a_D = 2'b00; a_if.fwd_b_D = 2'b00; a_if.branch_D = 0; a_if.stall_D = 1;
    for (int i = 1; i <= 3; i++) begin
      a_if.inst_F = 32'h1111_0000 * i;
      push("stall_hold", 64'h00A0_0000);
      tick();
      pop_check(64'(a_if.inst_D));
    end

    // flush wins over stall and masks the branch
    a_if.flush_D = 1; a_if.branch_D = 1; a_if.br_mode_D = 3'd0;
    push("flush_inst", 64'd0); push("flush_valid", 64'd0); push("flush_pcsrc", 64'd0);
    tick();
    pop_check(64'(a_if.inst_D)); pop_check(64'(a_if.valid_D)); pop_check(64'(a_if.pc_src_D));

    // branch target wraps modulo 2^32
    a_if.stall_D = 0; a_if.flush_D = 0; a_if.branch_D = 0;
    a_if.inst_F = 32'h0000_0001; a_if.pc_plus4_F = 32'hFFFF_FFFC;
    push("wrap_imm", 64'd1); push("wrap_pcbr", 64'd0);
    tick();
    pop_check(64'(a_if.imm_D)); pop_check(64'(a_if.pc_br_D));

    // reset mid-stream drops the pending W write and clears the file
    a_if.reg_write_W = 1; a_if.reg_id_W = 5'd7; a_if.result_W = 32'h0000_0077;
    a_if.inst_F = 32'h00E5_0000;
    tick();
    a_if.reg_write_W = 0;
    push("r7_stored", 64'h0000_0077); push("r5_stored", 64'h0000_DEAD);
    #1;
    pop_check(64'(a_if.rs_out_D)); pop_check(64'(a_if.rt_out_D));
    reset = 1; a_if.reg_write_W = 1; a_if.reg_id_W = 5'd9; a_if.result_W = 32'h0000_0099;
    tick();
    reset = 0; a_if.reg_write_W = 0;
    push("mid_rst_valid", 64'd0); push("mid_rst_inst", 64'd0);
    #1;
    pop_check(64'(a_if.valid_D)); pop_check(64'(a_if.inst_D));
    push("r7_cleared", 64'd0); push("r5_cleared", 64'd0);
    tick();
    pop_check(64'(a_if.rs_out_D)); pop_check(64'(a_if.rt_out_D));
    a_if.inst_F = 32'h0120_0000;
    push("r9_lost", 64'd0);
    tick();
    pop_check(64'(a_if.rs_out_D));

    // XLEN=64, NREG=16: rs field 21 aliases reg 5
    b_if.reg_write_W = 1; b_if.reg_id_W = 4'd5; b_if.result_W = 64'h1234_5678_9ABC_DEF0;
    push("b_alias_bypass", 64'h1234_5678_9ABC_DEF0);
    #1;
    pop_check(b_if.rs_out_D);
    tick();
    b_if.reg_write_W = 0;
    push("b_alias_stored", 64'h1234_5678_9ABC_DEF0); push("b_rt_stored", 64'h1234_5678_9ABC_DEF0);
    push("b_imm", 64'hFFFF_FFFF_FFFF_8000); push("b_pcbr", 64'h0000_0000_FFFE_0000);
    #1;
    pop_check(b_if.rs_out_D); pop_check(b_if.rt_out_D);
    pop_check(b_if.imm_D); pop_check(b_if.pc_br_D);
    b_if.branch_D = 1; b_if.fwd_a_D = 2'b01; b_if.alu_out_M = 64'h8000_0000_0000_0000;
    b_if.br_mode_D = 3'd4; push("b_ltz", 64'd1); #1; pop_check(64'(b_if.pc_src_D));
    b_if.br_mode_D = 3'd5; push("b_gez", 64'd0); #1; pop_check(64'(b_if.pc_src_D));
    b_if.alu_out_M = 64'h0000_0001_0000_0000;
    b_if.br_mode_D = 3'd3; push("b_gtz_hi", 64'd1); #1; pop_check(64'(b_if.pc_src_D));

    if (sb.size() != 0) begin
      errors++;
      $error("FAIL scoreboard_leftover: observed=%0d required=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
